adc_seq_controller: RTL

Parametrised next-generation serial ADC controller for AD76xx-class simultaneous-sampling ADCs. Supports N_LINES serial data lanes, N_CHAN channels and W_DATA-bit words, with continuous or single-shot conversion. Delivers channel-indexed parallel words to the pid core, and flags overrun and busy-timeout faults. It sits between the frontpanel controller and the ADC pins; sclk is forwarded externally, gated by sclk_en_out.

---
 rtl/adc_seq_controller.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/adc_seq_controller.sv
// Serial ADC sequencer for AD76xx-class simultaneous-sampling converters: paces convst,
// deserialises the multi-lane readout into channel-indexed words and flags overrun/timeout.
module adc_seq_controller #(
  parameter int W_DATA      = 18,
  parameter int N_CHAN      = 8,
  parameter int N_LINES     = 2,
  parameter int MIN_T_CYCLE = 85,
  parameter int TIMEOUT     = 255,
  parameter int OS_INIT     = 1,
  parameter int OS_MIN      = 1,
  localparam int SLOTS   = N_CHAN / N_LINES,
  localparam int RD_LEN  = W_DATA * SLOTS,
  localparam int CH_W    = (SLOTS > 1) ? $clog2(SLOTS) : 1,
  localparam int WC_W    = (W_DATA > 1) ? $clog2(W_DATA) : 1,
  localparam int CNT_MAX = (RD_LEN > MIN_T_CYCLE) ? ((RD_LEN > TIMEOUT) ? RD_LEN : TIMEOUT)
                                                  : ((MIN_T_CYCLE > TIMEOUT) ? MIN_T_CYCLE : TIMEOUT),
  localparam int CNT_W   = $clog2(CNT_MAX + 1)
) (
  input  logic                        clk_in,
  input  logic                        reset_in,
  input  logic                        busy_in,
  input  logic [N_LINES-1:0]          data_in,
  input  logic [2:0]                  os_in,
  input  logic                        update_in,
  input  logic                        mode_in,
  input  logic                        start_in,
  input  logic                        stop_in,
  input  logic                        err_clr_in,
  output logic [2:0]                  os_out,
  output logic                        convst_out,
  output logic                        reset_out,
  output logic                        n_cs_out,
  output logic                        sclk_en_out,
  output logic [N_LINES*W_DATA-1:0]   data_out,
  output logic [CH_W-1:0]             chan_out,
  output logic                        data_valid_out,
  output logic                        frame_done_out,
  output logic                        active_out,
  output logic                        overrun_out,
  output logic                        timeout_out
);

  localparam logic [2:0] OS_RST = (OS_INIT < OS_MIN) ? 3'(OS_MIN) :
                                  (OS_INIT > 6)      ? 3'd6 : 3'(OS_INIT);

  function automatic logic [2:0] clamp_os(input logic [2:0] v);
    if (int'(v) < OS_MIN) return 3'(OS_MIN);
    else if (v > 3'd6)    return 3'd6;
    else                  return v;
  endfunction

  typedef enum logic [1:0] {C_IDLE, C_CONVST, C_CONV} c_state_t;
  typedef enum logic [1:0] {R_IDLE, R_READ, R_WAIT} r_state_t;

  c_state_t c_state, c_next;
  r_state_t r_state, r_next;

  logic                      busy_m, busy_s, busy_d, busy_rise;
  logic [CNT_W-1:0]          cyc_cnt;
  logic                      busy_seen, stop_pend, stop_any, timeout_set;
  logic [2:0]                os_pend;
  logic [WC_W-1:0]           wcnt;
  logic [CH_W-1:0]           slot;
  logic                      abort, shifting, overrun_set, word_end, frame_end;
  logic [N_LINES*W_DATA-1:0] shreg, word_next;

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) {busy_m, busy_s, busy_d} <= '0;
    else          {busy_m, busy_s, busy_d} <= {busy_in, busy_m, busy_s};
  end

  assign busy_rise = busy_s & ~busy_d;
  assign stop_any  = stop_pend | stop_in;

  // cyc_cnt is zero in the CONVST cycle, so it equals cycles elapsed since convst fell
  always_comb begin
    c_next      = c_state;
    timeout_set = 1'b0;
    case (c_state)
      C_IDLE:   if (start_in && !stop_in) c_next = C_CONVST;
      C_CONVST: c_next = C_CONV;
      C_CONV: begin
        if (!busy_seen && !busy_rise && cyc_cnt >= CNT_W'(TIMEOUT - 1)) begin
          timeout_set = 1'b1;
          c_next      = C_IDLE;
        end else if (busy_seen && !busy_s) begin
          if (mode_in || stop_any)                      c_next = C_IDLE;
          else if (cyc_cnt >= CNT_W'(MIN_T_CYCLE - 1))  c_next = C_CONVST;
        end
      end
      default: c_next = C_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      c_state   <= C_IDLE;
      cyc_cnt   <= '0;
      busy_seen <= 1'b0;
      stop_pend <= 1'b0;
      os_pend   <= OS_RST;
      os_out    <= OS_RST;
    end else begin
      c_state <= c_next;
      if (c_next == C_CONVST)     cyc_cnt <= '0;
      else if (cyc_cnt != '1)     cyc_cnt <= cyc_cnt + CNT_W'(1);
      if (c_next == C_CONVST)                     busy_seen <= 1'b0;
      else if (busy_rise && c_state != C_IDLE)    busy_seen <= 1'b1;
      if (c_next == C_IDLE) stop_pend <= 1'b0;
      else if (stop_in)     stop_pend <= 1'b1;
      if (update_in) os_pend <= clamp_os(os_in);
      if (c_state == C_IDLE || c_next == C_CONVST)
        os_out <= update_in ? clamp_os(os_in) : os_pend;
    end
  end

  // A busy rise during READ is an overrun: it takes priority over any capture that cycle
  assign overrun_set = (r_state == R_READ) && busy_rise;
  assign shifting    = (r_state == R_READ) && !abort && !busy_rise;
  assign word_end    = shifting && (wcnt == WC_W'(W_DATA - 1));
  assign frame_end   = word_end && (slot == CH_W'(SLOTS - 1));

  always_comb begin
    word_next = '0;
    for (int l = 0; l < N_LINES; l++)
      word_next[l*W_DATA +: W_DATA] = {shreg[l*W_DATA +: W_DATA-1], data_in[l]};
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (busy_rise) r_next = R_READ;
      R_READ:  if (frame_end) r_next = R_WAIT;
      R_WAIT:  if (!busy_s)   r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_state        <= R_IDLE;
      wcnt           <= '0;
      slot           <= '0;
      abort          <= 1'b0;
      shreg          <= '0;
      data_out       <= '0;
      chan_out       <= '0;
      data_valid_out <= 1'b0;
      frame_done_out <= 1'b0;
      overrun_out    <= 1'b0;
      timeout_out    <= 1'b0;
    end else begin
      r_state        <= r_next;
      abort          <= overrun_set;
      data_valid_out <= word_end;
      frame_done_out <= frame_end;
      if (r_state == R_IDLE || overrun_set) begin
        wcnt <= '0;
        slot <= '0;
      end else if (shifting) begin
        shreg <= word_next;
        if (word_end) begin
          wcnt <= '0;
          slot <= slot + CH_W'(1);
        end else begin
          wcnt <= wcnt + WC_W'(1);
        end
      end
      if (word_end) begin
        data_out <= word_next;
        chan_out <= slot;
      end
      overrun_out <= overrun_set | (overrun_out & ~err_clr_in);
      timeout_out <= timeout_set | (timeout_out & ~err_clr_in);
    end
  end

  assign convst_out  = (c_state != C_CONVST);
  assign active_out  = (c_state != C_IDLE);
  assign n_cs_out    = !((r_state == R_READ) && !abort);
  assign sclk_en_out = (r_state == R_READ) && !abort;
  assign reset_out   = reset_in;

endmodule
